// File: rtl/writeback_stage.sv
// WB stage of the 5-stage core: MEM/WB pipeline register, result select, load
// alignment/extension and the register-file write port with a retired counter.
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_reg_write,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_wb_sel,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_pc_plus4,
  input  logic [XLEN-1:0]  in_load_word,
  input  logic [2:0]       in_funct3,
  output logic             write_enable,
  output logic [4:0]       addr_rd,
  output logic [XLEN-1:0]  data_rd,
  output logic             wb_valid,
  output logic             load_fault,
  output logic [CNT_W-1:0] retired
);

  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  logic             valid_q, valid_d;
  logic             reg_write_q, reg_write_d;
  logic [4:0]       rd_q, rd_d;
  logic [1:0]       wb_sel_q, wb_sel_d;
  logic [XLEN-1:0]  alu_q, alu_d;
  logic [XLEN-1:0]  pc4_q, pc4_d;
  logic [XLEN-1:0]  load_q, load_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  // Flush beats stall; a flushed bubble clears every field.
  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    rd_d        = rd_q;
    wb_sel_d    = wb_sel_q;
    alu_d       = alu_q;
    pc4_d       = pc4_q;
    load_d      = load_q;
    funct3_d    = funct3_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      rd_d        = '0;
      wb_sel_d    = '0;
      alu_d       = '0;
      pc4_d       = '0;
      load_d      = '0;
      funct3_d    = '0;
    end else if (!stall) begin
      valid_d     = in_valid;
      reg_write_d = in_reg_write;
      rd_d        = in_rd;
      wb_sel_d    = in_wb_sel;
      alu_d       = in_alu_result;
      pc4_d       = in_pc_plus4;
      load_d      = in_load_word;
      funct3_d    = in_funct3;
    end
    // The held instruction leaves WB when it is replaced or flushed away.
    retire    = valid_q & (~stall | flush);
    retired_d = retired_q + CNT_W'(retire);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wb_sel_q    <= '0;
      alu_q       <= '0;
      pc4_q       <= '0;
      load_q      <= '0;
      funct3_q    <= '0;
      retired_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wb_sel_q    <= wb_sel_d;
      alu_q       <= alu_d;
      pc4_q       <= pc4_d;
      load_q      <= load_d;
      funct3_q    <= funct3_d;
      retired_q   <= retired_d;
    end
  end

  logic [1:0]      boff;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_val;
  logic            misaligned;
  logic            illegal;
  logic [XLEN-1:0] result;

  always_comb begin
    boff       = alu_q[1:0];
    ld_byte    = load_q[8*boff +: 8];
    ld_half    = boff[1] ? load_q[31:16] : load_q[15:0];
    load_val   = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3_q)
      3'd0: load_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'd1: begin
        load_val   = {{(XLEN-16){ld_half[15]}}, ld_half};
        misaligned = boff[0];
      end
      3'd2: begin
        load_val   = load_q;
        misaligned = (boff != 2'd0);
      end
      3'd4: load_val = {{(XLEN-8){1'b0}}, ld_byte};
      3'd5: begin
        load_val   = {{(XLEN-16){1'b0}}, ld_half};
        misaligned = boff[0];
      end
      default: illegal = 1'b1;
    endcase

    load_fault = valid_q & (wb_sel_q == WB_LOAD) & (misaligned | illegal);

    // Reserved select 3 falls through to the ALU result.
    case (wb_sel_q)
      WB_LOAD: result = load_val;
      WB_PC4:  result = pc4_q;
      default: result = alu_q;
    endcase

    data_rd      = load_fault ? '0 : result;
    write_enable = valid_q & reg_write_q & (rd_q != 5'd0) & ~load_fault;
    addr_rd      = rd_q;
    wb_valid     = valid_q;
    retired      = retired_q;
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: table of single-cycle vectors through a scoreboard,
// then hand sequences for stall, flush+stall, reset mid-stall and counter wrap.
module tb_writeback_stage;

  logic        clock = 1'b0;
  logic        reset, stall, flush;
  logic        in_valid, in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result, in_pc_plus4, in_load_word;
  logic [2:0]  in_funct3;
  logic        write_enable, wb_valid, load_fault;
  logic [4:0]  addr_rd;
  logic [31:0] data_rd;
  logic [63:0] retired;

  writeback_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_rd(in_rd),
    .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result),
    .in_pc_plus4(in_pc_plus4), .in_load_word(in_load_word),
    .in_funct3(in_funct3), .write_enable(write_enable), .addr_rd(addr_rd),
    .data_rd(data_rd), .wb_valid(wb_valid), .load_fault(load_fault),
    .retired(retired)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] lw;
    logic [2:0]  f3;
    logic        e_we;
    logic [31:0] e_data;
    logic        e_fault;
  } vec_t;

  int tests = 0;
  int failed = 0;
  logic [39:0] exp_q[$];
  logic [63:0] m_ret = '0;
  logic        m_v = 1'b0;
  vec_t        vecs[16];

  function automatic vec_t mk(input logic v, input logic rw, input logic [4:0] rd,
                              input logic [1:0] sel, input logic [31:0] alu,
                              input logic [31:0] pc4, input logic [31:0] lw,
                              input logic [2:0] f3, input logic e_we,
                              input logic [31:0] e_data, input logic e_fault);
    vec_t r;
    r.v = v; r.rw = rw; r.rd = rd; r.sel = sel; r.alu = alu; r.pc4 = pc4;
    r.lw = lw; r.f3 = f3; r.e_we = e_we; r.e_data = e_data; r.e_fault = e_fault;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic set_in(input vec_t x);
    in_valid      = x.v;
    in_reg_write  = x.rw;
    in_rd         = x.rd;
    in_wb_sel     = x.sel;
    in_alu_result = x.alu;
    in_pc_plus4   = x.pc4;
    in_load_word  = x.lw;
    in_funct3     = x.f3;
  endtask

  task automatic push_exp(input logic we, input logic [4:0] rd, input logic [31:0] d,
                          input logic v, input logic f);
    exp_q.push_back({we, rd, d, v, f});
  endtask

  // Advance one edge; the model tracks what WB holds and the retire count.
  task automatic step(input string name);
    logic [39:0] e;
    if (reset) begin
      m_ret = '0;
      m_v   = 1'b0;
    end else begin
      if (m_v && (!stall || flush)) m_ret = m_ret + 64'd1;
      m_v = flush ? 1'b0 : (stall ? m_v : in_valid);
    end
    @(posedge clock);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(name, {24'd0, write_enable, addr_rd, data_rd, wb_valid, load_fault},
            {24'd0, e});
    end
    check({name, "_retired"}, retired, m_ret);
  endtask

  localparam logic [31:0] LWORD = 32'h80FF_7F01;
  logic [63:0] r_before;

  initial begin
    vecs[0]  = mk(1, 1, 5'd5, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 3'd0, 1, 32'h1234_5678, 0);
    vecs[1]  = mk(1, 1, 5'd0, 2'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 3'd0, 0, 32'hFFFF_FFFF, 0);
    vecs[2]  = mk(1, 1, 5'd3, 2'd1, 32'h0000_1000, 32'h0, LWORD, 3'd0, 1, 32'h0000_0001, 0);
    vecs[3]  = mk(1, 1, 5'd3, 2'd1, 32'h0000_1001, 32'h0, LWORD, 3'd0, 1, 32'h0000_007F, 0);
    vecs[4]  = mk(1, 1, 5'd3, 2'd1, 32'h0000_1002, 32'h0, LWORD, 3'd0, 1, 32'hFFFF_FFFF, 0);
    vecs[5]  = mk(1, 1, 5'd3, 2'd1, 32'h0000_1003, 32'h0, LWORD, 3'd0, 1, 32'hFFFF_FF80, 0);
    vecs[6]  = mk(1, 1, 5'd4, 2'd1, 32'h0000_2002, 32'h0, LWORD, 3'd5, 1, 32'h0000_80FF, 0);
    vecs[7]  = mk(1, 1, 5'd4, 2'd1, 32'h0000_2002, 32'h0, LWORD, 3'd1, 1, 32'hFFFF_80FF, 0);
    vecs[8]  = mk(1, 1, 5'd6, 2'd1, 32'h0000_3002, 32'h0, LWORD, 3'd2, 0, 32'h0000_0000, 1);
    vecs[9]  = mk(1, 1, 5'd6, 2'd1, 32'h0000_3000, 32'h0, LWORD, 3'd3, 0, 32'h0000_0000, 1);
    vecs[10] = mk(1, 1, 5'd6, 2'd1, 32'h0000_3000, 32'h0, LWORD, 3'd2, 1, LWORD, 0);
    vecs[11] = mk(1, 1, 5'd1, 2'd2, 32'h0000_0055, 32'h0000_0400, 32'h0, 3'd0, 1, 32'h0000_0400, 0);
    vecs[12] = mk(1, 1, 5'd2, 2'd3, 32'hA5A5_0000, 32'h0000_0400, 32'h0, 3'd0, 1, 32'hA5A5_0000, 0);
    vecs[13] = mk(1, 0, 5'd9, 2'd0, 32'h0BAD_F00D, 32'h0, 32'h0, 3'd0, 0, 32'h0BAD_F00D, 0);
    vecs[14] = mk(0, 1, 5'd9, 2'd0, 32'h0000_0077, 32'h0, 32'h0, 3'd0, 0, 32'h0000_0077, 0);
    vecs[15] = mk(1, 1, 5'd31, 2'd1, 32'h0000_4003, 32'h0, LWORD, 3'd4, 1, 32'h0000_0080, 0);

    // Reset
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    set_in(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("reset0");
    step("reset1");
    reset = 1'b0;
    check("reset_outputs", {24'd0, write_enable, addr_rd, data_rd, wb_valid, load_fault}, 64'd0);
    check("reset_retired", retired, 64'd0);

    // Table vectors, one instruction per cycle
    for (int i = 0; i < 16; i++) begin
      set_in(vecs[i]);
      push_exp(vecs[i].e_we, vecs[i].rd, vecs[i].e_data, vecs[i].v, vecs[i].e_fault);
      step($sformatf("vec%0d", i));
    end

    // Randomized ALU writes
    for (int i = 0; i < 8; i++) begin
      vec_t x;
      x = mk(1, 1, 5'($urandom_range(1, 31)), 2'd0, $urandom, 32'h0, 32'h0, 3'd0, 1, 32'h0, 0);
      x.e_data = x.alu;
      set_in(x);
      push_exp(1'b1, x.rd, x.alu, 1'b1, 1'b0);
      step($sformatf("rand%0d", i));
    end

    // Stall holds an x7 write for three cycles
    set_in(mk(1, 1, 5'd7, 2'd0, 32'hCAFE_0007, 32'h0, 32'h0, 3'd0, 0, 0, 0));
    push_exp(1'b1, 5'd7, 32'hCAFE_0007, 1'b1, 1'b0);
    step("stall_capture");
    r_before = retired;
    stall = 1'b1;
    set_in(mk(1, 1, 5'd9, 2'd0, 32'h0, 32'h0, 32'h0, 3'd0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b1, 5'd7, 32'hCAFE_0007, 1'b1, 1'b0);
      step($sformatf("stall_hold%0d", i));
    end
    check("stall_no_retire", retired, r_before);
    stall = 1'b0;
    set_in(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push_exp(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    step("stall_release");
    check("stall_release_retire", retired, r_before + 64'd1);

    // Flush and stall together
    set_in(mk(1, 1, 5'd8, 2'd0, 32'h0000_0808, 32'h0, 32'h0, 3'd0, 0, 0, 0));
    push_exp(1'b1, 5'd8, 32'h0000_0808, 1'b1, 1'b0);
    step("flush_capture");
    r_before = retired;
    stall = 1'b1; flush = 1'b1;
    set_in(mk(1, 1, 5'd10, 2'd0, 32'h1111_1111, 32'h0, 32'h0, 3'd0, 0, 0, 0));
    step("flush_stall");
    check("flush_wb_valid", {63'd0, wb_valid}, 64'd0);
    check("flush_we", {63'd0, write_enable}, 64'd0);
    check("flush_retire", retired, r_before + 64'd1);
    stall = 1'b0; flush = 1'b0;

    // Reset while stalled discards the held instruction
    set_in(mk(1, 1, 5'd12, 2'd0, 32'h0000_0C0C, 32'h0, 32'h0, 3'd0, 0, 0, 0));
    push_exp(1'b1, 5'd12, 32'h0000_0C0C, 1'b1, 1'b0);
    step("rst_capture");
    stall = 1'b1;
    step("rst_stall");
    reset = 1'b1;
    push_exp(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    step("rst_mid_stall");
    check("rst_mid_stall_retired", retired, 64'd0);
    reset = 1'b0; stall = 1'b0;

    // Counter wraps from all-ones to zero
    set_in(mk(1, 1, 5'd1, 2'd0, 32'h0000_0001, 32'h0, 32'h0, 3'd0, 0, 0, 0));
    push_exp(1'b1, 5'd1, 32'h0000_0001, 1'b1, 1'b0);
    step("wrap_capture");
    force dut.retired_q = '1;
    m_ret = '1;
    #1;
    release dut.retired_q;
    set_in(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push_exp(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    step("wrap");
    check("wrap_zero", retired, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
